// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: the carry chain is cut into STAGES equal
// slices, one per register stage, with a valid/ready handshake and global stall.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             Sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ov,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SL   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers: operands (B already conditioned for subtract), partial sum, slice carry.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ov_q;

    logic [WIDTH-1:0] in_a  [STAGES];
    logic [WIDTH-1:0] in_b  [STAGES];
    logic [WIDTH-1:0] in_s  [STAGES];
    logic             in_c  [STAGES];
    logic             in_v  [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];
    logic [SL:0]      slice_sum [STAGES];
    logic             nxt_ov;
    logic             stall;

    // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
    always_comb begin
        stall = v_q[LAST] && !out_ready;

        in_a[0] = A;
        in_b[0] = Sub ? ~B : B;
        in_c[0] = Sub ? 1'b1 : Ci;
        in_s[0] = '0;
        in_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            in_a[k] = a_q[k-1];
            in_b[k] = b_q[k-1];
            in_c[k] = c_q[k-1];
            in_s[k] = s_q[k-1];
            in_v[k] = v_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, in_a[k][k*SL +: SL]} + {1'b0, in_b[k][k*SL +: SL]}
                         + (SL+1)'(in_c[k]);
            nxt_s[k]               = in_s[k];
            nxt_s[k][k*SL +: SL]   = slice_sum[k][SL-1:0];
            nxt_c[k]               = slice_sum[k][SL];
        end

        nxt_ov = (in_a[LAST][WIDTH-1] == in_b[LAST][WIDTH-1])
              && (nxt_s[LAST][WIDTH-1] != in_a[LAST][WIDTH-1]);
    end

    // Results only move on a valid slot, so bubbles leave S/Co/Ov at their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= in_v[k];
                if (in_v[k]) begin
                    s_q[k] <= nxt_s[k];
                    c_q[k] <= nxt_c[k];
                end
            end
            if (in_v[LAST]) ov_q <= nxt_ov;
        end
    end

    // NOTE: operand registers carry no reset; they are only consumed behind a set valid bit.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                if (in_v[k]) begin
                    a_q[k] <= in_a[k];
                    b_q[k] <= in_b[k];
                end
            end
        end
    end

    assign in_ready  = !stall;
    assign S         = s_q[LAST];
    assign Co        = c_q[LAST];
    assign Ov        = ov_q;
    assign out_valid = v_q[LAST];

endmodule
